// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between two requesters (A, B) sharing a
// 1024x12 single-port memory with a bidirectional data bus.
// Every transaction runs IDLE -> ACCESS -> COMPLETE -> IDLE, one cycle per state.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        wr_a,
  input  logic        wr_b,
  input  logic [9:0]  addr_a,
  input  logic [9:0]  addr_b,
  input  logic [11:0] wdata_a,
  input  logic [11:0] wdata_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        done_a,
  output logic        done_b,
  output logic [11:0] rdata_a,
  output logic [11:0] rdata_b,
  output logic        busy,
  output logic [9:0]  mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  inout  wire  [11:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  state_t      state;
  state_t      state_nxt;
  port_t       owner;        // port that owns the transaction in flight
  port_t       last_served;  // port whose transaction completed most recently
  port_t       winner;       // port that would be granted if IDLE accepts now
  logic        accept;       // IDLE is taking a new request at this edge
  logic        drive_bus;    // put wdata_q onto mem_data this cycle
  logic        wr_q;
  logic [9:0]  addr_q;
  logic [11:0] wdata_q;

  // Round-robin choice: a lone requester wins; on a tie the port that was
  // not served last wins.
  always_comb begin
    winner = PORT_A;
    if (req_a && req_b) begin
      winner = (last_served == PORT_B) ? PORT_A : PORT_B;
    end else if (req_b) begin
      winner = PORT_B;
    end
  end

  // Next-state logic and the state-decoded outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    done_a    = 1'b0;
    done_b    = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    drive_bus = 1'b0;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        busy      = 1'b1;
        gnt_a     = (owner == PORT_A);
        gnt_b     = (owner == PORT_B);
        mem_re    = !wr_q;
        mem_we    = wr_q;
        drive_bus = wr_q;
        state_nxt = COMPLETE;
      end
      COMPLETE: begin
        busy      = 1'b1;
        gnt_a     = (owner == PORT_A);
        gnt_b     = (owner == PORT_B);
        done_a    = (owner == PORT_A);
        done_b    = (owner == PORT_B);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The latched address stays on the bus between transactions.
  assign mem_addr = addr_q;

  // Write data reaches the bus only during a write ACCESS; a read ACCESS
  // leaves the bus released for the memory, so the two never collide.
  assign mem_data = drive_bus ? wdata_q : 12'bz;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winner's command on acceptance; record the served port at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= PORT_A;
      last_served <= PORT_B;
      wr_q        <= 1'b0;
      addr_q      <= 10'd0;
      wdata_q     <= 12'd0;
    end else begin
      if (accept) begin
        owner   <= winner;
        wr_q    <= (winner == PORT_B) ? wr_b    : wr_a;
        addr_q  <= (winner == PORT_B) ? addr_b  : addr_a;
        wdata_q <= (winner == PORT_B) ? wdata_b : wdata_a;
      end
      if (state == COMPLETE) begin
        last_served <= owner;
      end
    end
  end

  // Capture read data into the owner's result register as ACCESS ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= 12'd0;
      rdata_b <= 12'd0;
    end else if (state == ACCESS && !wr_q) begin
      if (owner == PORT_A) begin
        rdata_a <= mem_data;
      end else begin
        rdata_b <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by random traffic. A
// transaction-level reference model predicts each accepted transaction; a
// negedge monitor compares the DUT against those predictions.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0, wr_a = 1'b0, wr_b = 1'b0;
  logic [9:0]  addr_a = '0, addr_b = '0;
  logic [11:0] wdata_a = '0, wdata_b = '0;
  logic        gnt_a, gnt_b, done_a, done_b, busy, mem_re, mem_we;
  logic [11:0] rdata_a, rdata_b;
  logic [9:0]  mem_addr;
  wire  [11:0] mem_data;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .wr_a(wr_a), .wr_b(wr_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_data(mem_data)
  );

  // Contents of a word that has never been written.
  function automatic logic [11:0] init_val(input logic [9:0] a);
    return {a, 2'b10} ^ 12'h5A3;
  endfunction

  // ---------------- external memory ----------------
  logic [11:0] mem [1024];
  bit          mem_written [1024];
  logic [11:0] mem_rd;
  assign mem_rd   = mem_written[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
  assign mem_data = mem_re ? mem_rd : 12'bz;
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]         <= mem_data;
      mem_written[mem_addr] <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          acc;    // edge that accepted the request
    bit          port;   // 0 = A, 1 = B
    bit          wr;
    logic [9:0]  addr;
    logic [11:0] wdata;
  } txn_t;

  typedef struct {
    bit port;
    int cyc;
  } done_t;

  txn_t  exp_q[$];
  done_t done_log[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    we_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, want);
    end
  endtask

  // ---------------- reference model ----------------
  // Rules: accept in IDLE when any request is present, round-robin winner,
  // the transaction occupies the next two cycles, the memory sees the write
  // as ACCESS ends, and the read value lands in the owner's rdata at that edge.
  logic [11:0] ref_mem [1024];
  bit          ref_written [1024];
  bit          have_cur  = 1'b0;
  txn_t        cur;
  bit          last_b    = 1'b1;
  int          next_free = 0;
  logic [11:0] exp_rd_a  = '0, exp_rd_b = '0;
  logic [9:0]  exp_addr  = '0;

  function automatic logic [11:0] ref_rd(input logic [9:0] a);
    return ref_written[a] ? ref_mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (have_cur && cyc == cur.acc + 1 && cur.wr) begin
      ref_mem[cur.addr]     = cur.wdata;
      ref_written[cur.addr] = 1'b1;
    end
    if (rst) begin
      have_cur  = 1'b0;
      last_b    = 1'b1;
      exp_rd_a  = '0;
      exp_rd_b  = '0;
      exp_addr  = '0;
      next_free = cyc + 1;
      exp_q.delete();
    end else begin
      if (have_cur && cyc == cur.acc + 1 && !cur.wr) begin
        if (cur.port) exp_rd_b = ref_rd(cur.addr);
        else          exp_rd_a = ref_rd(cur.addr);
      end
      if (have_cur && cyc == cur.acc + 2) begin
        last_b   = cur.port;
        have_cur = 1'b0;
      end
      if (cyc >= next_free && (req_a || req_b)) begin
        cur.port  = (req_a && req_b) ? !last_b : req_b;
        cur.wr    = cur.port ? wr_b    : wr_a;
        cur.addr  = cur.port ? addr_b  : addr_a;
        cur.wdata = cur.port ? wdata_b : wdata_a;
        cur.acc   = cyc;
        have_cur  = 1'b1;
        exp_addr  = cur.addr;
        next_free = cyc + 3;
        exp_q.push_back(cur);
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    txn_t       e;
    done_t      d;
    bit         in_acc, in_cmp;
    logic [6:0] exp_ctrl, act_ctrl;
    in_acc = 1'b0;
    in_cmp = 1'b0;
    e      = '{default: '0};
    if (exp_q.size() > 0) begin
      e      = exp_q[0];
      in_acc = (cyc == e.acc);
      in_cmp = (cyc == e.acc + 1);
    end
    exp_ctrl = {in_acc || in_cmp,
                (in_acc || in_cmp) && !e.port, (in_acc || in_cmp) && e.port,
                in_cmp && !e.port, in_cmp && e.port,
                in_acc && !e.wr, in_acc && e.wr};
    act_ctrl = {busy, gnt_a, gnt_b, done_a, done_b, mem_re, mem_we};
    check("ctrl{busy,gnt_a,gnt_b,done_a,done_b,re,we}", 32'(act_ctrl), 32'(exp_ctrl));
    check("mem_addr", 32'(mem_addr), 32'(exp_addr));
    check("rdata_a", 32'(rdata_a), 32'(exp_rd_a));
    check("rdata_b", 32'(rdata_b), 32'(exp_rd_b));
    if (in_acc && e.wr) check("write_bus_data", 32'(mem_data), 32'(e.wdata));
    if (mem_we) we_cnt++;
    if (done_a) begin d.port = 1'b0; d.cyc = cyc; done_log.push_back(d); end
    if (done_b) begin d.port = 1'b1; d.cyc = cyc; done_log.push_back(d); end
    if (in_cmp) void'(exp_q.pop_front());
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request pulse; returns in the IDLE cycle after completion.
  task automatic do_req(input bit port, input bit wr, input logic [9:0] addr,
                        input logic [11:0] wdata);
    if (port) begin req_b = 1'b1; wr_b = wr; addr_b = addr; wdata_b = wdata; end
    else      begin req_a = 1'b1; wr_a = wr; addr_a = addr; wdata_a = wdata; end
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int start, we0, n;

    // Reset, with a request that must be ignored while rst is high.
    req_a = 1'b1;
    repeat (3) tick();
    rst   = 1'b0;
    req_a = 1'b0;
    check("reset_ctrl", 32'({busy, gnt_a, gnt_b, done_a, done_b, mem_re, mem_we}), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_rdata", 32'({rdata_a, rdata_b}), 32'd0);

    // Single write then read by A.
    done_log.delete();
    we0   = we_cnt;
    start = cyc;
    do_req(1'b0, 1'b1, 10'h155, 12'hABC);
    check("write_we_cycles", 32'(we_cnt - we0), 32'd1);
    check("write_done_count", 32'(done_log.size()), 32'd1);
    if (done_log.size() > 0) begin
      check("write_done_port", 32'(done_log[0].port), 32'd0);
      check("write_done_latency", 32'(done_log[0].cyc - start), 32'd2);
    end
    do_req(1'b0, 1'b0, 10'h155, 12'h000);
    check("read_back_a", 32'(rdata_a), 32'hABC);
    check("read_back_b_untouched", 32'(rdata_b), 32'h000);

    // Both requesting continuously after reset: A, B, A, B, 3 cycles apart.
    do_reset();
    done_log.delete();
    req_a = 1'b1; wr_a = 1'b0; addr_a = 10'h001;
    req_b = 1'b1; wr_b = 1'b0; addr_b = 10'h002;
    repeat (12) tick();
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (3) tick();
    check("rr_done_count", 32'(done_log.size()), 32'd4);
    n = (done_log.size() < 4) ? done_log.size() : 4;
    for (int i = 0; i < n; i++) begin
      check("rr_order", 32'(done_log[i].port), 32'(i % 2));
      if (i > 0) check("rr_spacing", 32'(done_log[i].cyc - done_log[i-1].cyc), 32'd3);
    end

    // B requests for one cycle only, read at the top address.
    done_log.delete();
    do_req(1'b1, 1'b0, 10'h3FF, 12'h000);
    check("early_drop_done_count", 32'(done_log.size()), 32'd1);
    if (done_log.size() > 0) check("early_drop_done_port", 32'(done_log[0].port), 32'd1);
    check("early_drop_rdata_b", 32'(rdata_b), 32'(init_val(10'h3FF)));

    // Reset during ACCESS of an A write.
    done_log.delete();
    req_a = 1'b1; wr_a = 1'b1; addr_a = 10'h0AA; wdata_a = 12'h111;
    tick();
    req_a = 1'b0;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    @(negedge clk);
    #1;
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_done", 32'(done_log.size()), 32'd0);
    req_a = 1'b1; wr_a = 1'b0; addr_a = 10'h003;
    req_b = 1'b1; wr_b = 1'b0; addr_b = 10'h004;
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    tick();
    check("abort_then_priority_count", 32'(done_log.size()), 32'd1);
    if (done_log.size() > 0) check("abort_then_priority_port", 32'(done_log[0].port), 32'd0);

    // Inputs changed during ACCESS must not reach the memory.
    req_a = 1'b1; wr_a = 1'b1; addr_a = 10'h010; wdata_a = 12'h123;
    tick();
    req_a = 1'b0; addr_a = 10'h020; wdata_a = 12'hFFF;
    tick();
    tick();
    do_req(1'b0, 1'b0, 10'h010, 12'h000);
    check("inflight_latched_data", 32'(rdata_a), 32'h123);
    do_req(1'b0, 1'b0, 10'h020, 12'h000);
    check("inflight_other_addr_untouched", 32'(rdata_a), 32'(init_val(10'h020)));

    // Random traffic with occasional resets, checked by the monitor.
    for (int i = 0; i < 2000; i++) begin
      rst     = ($urandom_range(0, 149) == 0);
      req_a   = ($urandom_range(0, 2) != 0);
      req_b   = ($urandom_range(0, 2) != 0);
      wr_a    = ($urandom_range(0, 1) != 0);
      wr_b    = ($urandom_range(0, 1) != 0);
      addr_a  = ($urandom_range(0, 3) == 0) ? 10'(1023 - $urandom_range(0, 3))
                                            : 10'($urandom_range(0, 15));
      addr_b  = ($urandom_range(0, 3) == 0) ? 10'(1023 - $urandom_range(0, 3))
                                            : 10'($urandom_range(0, 15));
      wdata_a = 12'($urandom);
      wdata_b = 12'($urandom);
      tick();
    end
    rst   = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (5) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
